his_peak_finder: RTL



---
 rtl/his_peak_finder_pkg.sv | 8 +
 rtl/his_peak_finder_max.sv | 24 ++
 rtl/his_peak_finder.sv | 91 +++++++++
 3 files changed

// File: rtl/his_peak_finder_pkg.sv
// his_peak_finder_pkg: histogram geometry defaults shared with the builder, plus peak-finder FSM states
package his_peak_finder_pkg;
  localparam int DEF_BIN_NUM = 16;
  localparam int DEF_PIXEL_NUM = 4;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_THRESH = 2;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, OUT} state_t;
endpackage

// File: rtl/his_peak_finder_max.sv
// his_max_tracker: running maximum with strict-greater replace, so ties keep the lowest index
module his_max_tracker #(
  parameter int W = 8,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          res,
  input  logic          clear,
  input  logic          sample,
  input  logic [W-1:0]  value,
  input  logic [IW-1:0] index,
  output logic [W-1:0]  max,
  output logic [IW-1:0] max_idx
);
  always_ff @(posedge clk) begin
    if (res) begin
      max <= '0;
      max_idx <= '0;
    end else if (sample && (clear || value > max)) begin
      max <= value;
      max_idx <= index;
    end
  end
endmodule

// File: rtl/his_peak_finder.sv
// his_peak_finder: scans a completed histogram bank pixel by pixel and emits each pixel's peak bin over valid/ready
module his_peak_finder
  import his_peak_finder_pkg::*;
#(
  parameter int BIN_NUM = DEF_BIN_NUM,
  parameter int PIXEL_NUM = DEF_PIXEL_NUM,
  parameter int CNT_W = DEF_CNT_W,
  parameter int THRESH = DEF_THRESH,
  localparam int BIN_W = $clog2(BIN_NUM),
  localparam int PIX_W = $clog2(PIXEL_NUM),
  localparam int ADDR_W = BIN_W + PIX_W
) (
  input  logic              clk,
  input  logic              res,
  input  logic              his_done,
  input  logic              his_bank,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [CNT_W-1:0]  rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_pixel,
  output logic [BIN_W-1:0]  out_bin,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_hit,
  output logic              busy,
  output logic              scan_done,
  output logic              overrun
);
  localparam logic [CNT_W-1:0] TH = CNT_W'(THRESH);
  state_t state, nxt;
  logic [PIX_W-1:0] pix;
  logic [BIN_W-1:0] bin, dbin;
  logic dv, hs, last;
  assign rd_en = state == READ;
  assign out_valid = state == OUT;
  assign busy = state != IDLE;
  assign rd_addr = {pix, bin};
  assign out_pixel = pix;
  assign out_hit = out_cnt >= TH;
  assign hs = out_valid && out_ready;
  assign last = pix == PIX_W'(PIXEL_NUM - 1);
  always_comb begin
    nxt = state;
    nxt = (state == IDLE && his_done) ? READ :
          (state == READ && bin == BIN_W'(BIN_NUM - 1)) ? DRAIN :
          (state == DRAIN) ? OUT :
          hs ? (last ? IDLE : READ) : state;
  end
  always_ff @(posedge clk) begin
    if (res) state <= IDLE;
    else state <= nxt;
  end
  // dv/dbin delay the read strobe and bin by one cycle to line up with rd_data
  always_ff @(posedge clk) begin
    if (res) begin
      rd_bank <= 1'b0;
      pix <= '0;
      bin <= '0;
      dv <= 1'b0;
      dbin <= '0;
      scan_done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      dv <= rd_en;
      dbin <= bin;
      scan_done <= hs && last;
      overrun <= his_done && busy;
      if (state == IDLE && his_done) begin
        rd_bank <= his_bank;
        pix <= '0;
        bin <= '0;
      end else if (rd_en) bin <= bin + 1'b1;
      else if (hs && !last) begin
        pix <= pix + 1'b1;
        bin <= '0;
      end
    end
  end
  his_max_tracker #(.W(CNT_W), .IW(BIN_W)) u_max (
    .clk(clk),
    .res(res),
    .clear(dbin == '0),
    .sample(dv),
    .value(rd_data),
    .index(dbin),
    .max(out_cnt),
    .max_idx(out_bin)
  );
endmodule
